// File: rtl/multiplexor_nx1_secuencial_if.sv
// Bus bundle for the registered N-to-1 multiplexer.
// Signals:
//   enable, mode, selector, inputs        - control and flattened channel data, driven by the source side
//   data_out, channel, valid, sel_error   - registered results, driven by the mux
// Modports: master (source and consumer side), slave (the mux itself).
interface multiplexor_nx1_secuencial_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = $clog2(CHANNELS)
);
  logic                      enable;
  logic                      mode;
  logic [SELW-1:0]           selector;
  logic [CHANNELS*WIDTH-1:0] inputs;
  logic [WIDTH-1:0]          data_out;
  logic [SELW-1:0]           channel;
  logic                      valid;
  logic                      sel_error;

  modport master (
    output enable, mode, selector, inputs,
    input  data_out, channel, valid, sel_error
  );

  modport slave (
    input  enable, mode, selector, inputs,
    output data_out, channel, valid, sel_error
  );
endinterface

// File: rtl/multiplexor_nx1_secuencial.sv
// Registered N-to-1 multiplexer with manual select and round-robin scan modes.
// Ports:
//   clock    - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - slave modport: enable/mode/selector/inputs in,
//              data_out/channel/valid/sel_error out (all registered)
module multiplexor_nx1_secuencial #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input logic                          clock,
  input logic                          reset_n,
  multiplexor_nx1_secuencial_if.slave  bus
);

  localparam int unsigned     CNTW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   SEL_LIMIT = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CH   = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(DWELL - 1);

  logic [SELW-1:0]  cur_q, cur_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  channel_q, channel_d;
  logic             valid_q, valid_d;
  logic             sel_error_q, sel_error_d;

  logic             sel_ok;
  logic [SELW-1:0]  pick_ch;
  logic [WIDTH-1:0] pick_data;

  // Channel sampled at this edge: a legal manual selector, otherwise the current channel.
  always_comb begin
    sel_ok  = ({1'b0, bus.selector} < SEL_LIMIT);
    pick_ch = cur_q;
    if (!bus.mode && sel_ok) begin
      pick_ch = bus.selector;
    end
  end

  // Compare-based mux so a non-power-of-two channel count never indexes past the bus.
  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (pick_ch == SELW'(k)) begin
        pick_data = bus.inputs[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: hold everything when disabled except valid, which drops.
  always_comb begin
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    channel_d   = channel_q;
    sel_error_d = sel_error_q;
    valid_d     = 1'b0;

    if (bus.enable) begin
      valid_d   = 1'b1;
      data_d    = pick_data;
      channel_d = pick_ch;
      if (!bus.mode) begin
        // Manual: restarting the dwell count gives a later scan a full first dwell.
        cur_d       = pick_ch;
        cnt_d       = '0;
        sel_error_d = !sel_ok;
      end else begin
        // Scan: output labels the channel just sampled; cur moves on after DWELL samples.
        sel_error_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          cur_d = (cur_q == LAST_CH) ? '0 : cur_q + SELW'(1);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      channel_q   <= '0;
      valid_q     <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      channel_q   <= channel_d;
      valid_q     <= valid_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.channel   = channel_q;
  assign bus.valid     = valid_q;
  assign bus.sel_error = sel_error_q;

endmodule

// File: tb/tb_multiplexor_nx1_secuencial.sv
// Directed bench: a 4-channel DWELL=3 instance for manual/scan/freeze/mode tests,
// and a 3-channel DWELL=1 instance for out-of-range select and per-cycle scan.
module tb_multiplexor_nx1_secuencial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  multiplexor_nx1_secuencial_if #(.WIDTH(8), .CHANNELS(4), .SELW(2)) b4 ();
  multiplexor_nx1_secuencial_if #(.WIDTH(8), .CHANNELS(3), .SELW(2)) b3 ();

  multiplexor_nx1_secuencial #(.WIDTH(8), .CHANNELS(4), .DWELL(3), .SELW(2)) u4 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b4.slave)
  );

  multiplexor_nx1_secuencial #(.WIDTH(8), .CHANNELS(3), .DWELL(1), .SELW(2)) u3 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (b3.slave)
  );

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    // Mid-cycle asynchronous reset: outputs clear with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (b4.data_out !== 8'h00) $display("FAIL reset_data got %h expected 00", b4.data_out); else passed++;
    total++; if (b4.channel !== 2'd0) $display("FAIL reset_channel got %0d expected 0", b4.channel); else passed++;
    total++; if (b4.valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", b4.valid); else passed++;
    total++; if (b3.sel_error !== 1'b0 || b3.data_out !== 8'h00) $display("FAIL reset_u3 got err=%b data=%h expected 0/00", b3.sel_error, b3.data_out); else passed++;
    step();
    rst_n = 1'b1;
    b4.mode = 1'b1;
    step();
    total++; if (b4.valid !== 1'b1 || b4.channel !== 2'd0 || b4.data_out !== 8'h11) $display("FAIL release_scan got v=%b ch=%0d d=%h expected 1/0/11", b4.valid, b4.channel, b4.data_out); else passed++;
    total++; if (b3.channel !== 2'd2 || b3.data_out !== 8'hC2) $display("FAIL release_manual got ch=%0d d=%h expected 2/C2", b3.channel, b3.data_out); else passed++;
  endtask

  task automatic test_manual();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    b4.mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      b4.selector = 2'(s);
      step();
      total++; if (b4.data_out !== exp[s]) $display("FAIL manual_data sel=%0d got %h expected %h", s, b4.data_out, exp[s]); else passed++;
      total++; if (b4.channel !== 2'(s) || b4.valid !== 1'b1 || b4.sel_error !== 1'b0) $display("FAIL manual_flags sel=%0d got ch=%0d v=%b e=%b expected %0d/1/0", s, b4.channel, b4.valid, b4.sel_error, s); else passed++;
    end
  endtask

  task automatic test_scan();
    int ch;
    b4.mode     = 1'b0;
    b4.selector = 2'd0;
    step();
    b4.mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      ch = (i / 3) % 4;
      total++; if (b4.channel !== 2'(ch)) $display("FAIL scan_channel edge=%0d got %0d expected %0d", i, b4.channel, ch); else passed++;
      total++; if (b4.data_out !== 8'((ch + 1) * 17) || b4.valid !== 1'b1) $display("FAIL scan_data edge=%0d got %h v=%b expected %h/1", i, b4.data_out, b4.valid, 8'((ch + 1) * 17)); else passed++;
    end
  endtask

  task automatic test_freeze();
    step();
    total++; if (b4.channel !== 2'd0) $display("FAIL freeze_pre got %0d expected 0", b4.channel); else passed++;
    b4.enable = 1'b0;
    b4.inputs[7:0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (b4.valid !== 1'b0 || b4.channel !== 2'd0 || b4.data_out !== 8'h11) $display("FAIL freeze_hold cyc=%0d got v=%b ch=%0d d=%h expected 0/0/11", i, b4.valid, b4.channel, b4.data_out); else passed++;
    end
    b4.inputs[7:0] = 8'h11;
    b4.enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (b4.valid !== 1'b1 || b4.channel !== 2'd0) $display("FAIL freeze_resume cyc=%0d got v=%b ch=%0d expected 1/0", i, b4.valid, b4.channel); else passed++;
    end
    step();
    total++; if (b4.channel !== 2'd1 || b4.data_out !== 8'h22) $display("FAIL freeze_advance got ch=%0d d=%h expected 1/22", b4.channel, b4.data_out); else passed++;
  endtask

  task automatic test_mode_switch();
    b4.mode     = 1'b0;
    b4.selector = 2'd2;
    step();
    total++; if (b4.channel !== 2'd2 || b4.data_out !== 8'h33) $display("FAIL mode_manual got ch=%0d d=%h expected 2/33", b4.channel, b4.data_out); else passed++;
    b4.mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (b4.channel !== 2'd2) $display("FAIL mode_dwell cyc=%0d got %0d expected 2", i, b4.channel); else passed++;
    end
    step();
    total++; if (b4.channel !== 2'd3 || b4.data_out !== 8'h44) $display("FAIL mode_next got ch=%0d d=%h expected 3/44", b4.channel, b4.data_out); else passed++;
    b4.mode     = 1'b0;
    b4.selector = 2'd0;
    step();
    total++; if (b4.channel !== 2'd0 || b4.data_out !== 8'h11) $display("FAIL mode_back got ch=%0d d=%h expected 0/11", b4.channel, b4.data_out); else passed++;
    // Freeze and mode change together: freeze wins.
    b4.enable   = 1'b0;
    b4.mode     = 1'b1;
    b4.selector = 2'd1;
    step();
    total++; if (b4.valid !== 1'b0 || b4.channel !== 2'd0) $display("FAIL mode_freeze got v=%b ch=%0d expected 0/0", b4.valid, b4.channel); else passed++;
    b4.enable = 1'b1;
    step();
    total++; if (b4.valid !== 1'b1 || b4.channel !== 2'd0) $display("FAIL mode_after_freeze got v=%b ch=%0d expected 1/0", b4.valid, b4.channel); else passed++;
  endtask

  task automatic test_out_of_range();
    b3.mode     = 1'b0;
    b3.selector = 2'd1;
    step();
    total++; if (b3.channel !== 2'd1 || b3.data_out !== 8'hB1 || b3.sel_error !== 1'b0) $display("FAIL oor_pre got ch=%0d d=%h e=%b expected 1/B1/0", b3.channel, b3.data_out, b3.sel_error); else passed++;
    b3.selector = 2'd3;
    step();
    total++; if (b3.sel_error !== 1'b1 || b3.channel !== 2'd1 || b3.data_out !== 8'hB1) $display("FAIL oor_flag got e=%b ch=%0d d=%h expected 1/1/B1", b3.sel_error, b3.channel, b3.data_out); else passed++;
    b3.inputs[15:8] = 8'hB5;
    step();
    total++; if (b3.sel_error !== 1'b1 || b3.data_out !== 8'hB5 || b3.valid !== 1'b1) $display("FAIL oor_track got e=%b d=%h v=%b expected 1/B5/1", b3.sel_error, b3.data_out, b3.valid); else passed++;
    b3.selector = 2'd2;
    step();
    total++; if (b3.sel_error !== 1'b0 || b3.channel !== 2'd2 || b3.data_out !== 8'hC2) $display("FAIL oor_clear got e=%b ch=%0d d=%h expected 0/2/C2", b3.sel_error, b3.channel, b3.data_out); else passed++;
  endtask

  task automatic test_dwell1();
    logic [7:0] d3 [3] = '{8'hA0, 8'hB5, 8'hC2};
    int         ch;
    b3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ch = (2 + i) % 3;
      total++; if (b3.channel !== 2'(ch) || b3.data_out !== d3[ch]) $display("FAIL dwell1 edge=%0d got ch=%0d d=%h expected %0d/%h", i, b3.channel, b3.data_out, ch, d3[ch]); else passed++;
    end
  endtask

  initial begin
    b4.enable   = 1'b1;
    b4.mode     = 1'b0;
    b4.selector = 2'd3;
    b4.inputs   = {8'h44, 8'h33, 8'h22, 8'h11};
    b3.enable   = 1'b1;
    b3.mode     = 1'b0;
    b3.selector = 2'd2;
    b3.inputs   = {8'hC2, 8'hB1, 8'hA0};
    test_reset();
    test_manual();
    test_scan();
    test_freeze();
    test_mode_switch();
    test_out_of_range();
    test_dwell1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d of %0d passed", passed, total);
    $fatal(1);
  end

endmodule
